uart_tx_arbiter: RTL

//  Shares one UART transmitter among NUM_REQ byte-stream requesters with round-robin arbitration.
//  A requester holds the grant for a whole packet, until it transfers a byte flagged last.

---
 rtl/uart_tx_arbiter_pkg.sv | 14 +
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 45 ++++
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// This package holds the FSM state encoding and the default byte width.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } tx_state_e;

  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the UART enable/busy handshake.
// The arbiter connects through the slave modport; clients and the UART connect through master.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          uart_enable;
  logic [DATA_WIDTH-1:0]         uart_data;
  logic                          uart_busy;

  modport master (
    output req_valid, req_data, req_last, uart_busy,
    input  req_ready, uart_enable, uart_data
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_busy,
    output req_ready, uart_enable, uart_data
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational rotate-priority encoder: lowest valid index at or after ptr wins,
// unless a packet is locked, in which case only the locked requester may be granted.
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               lock_i,
  input  logic [IDX_W-1:0]   grant_id_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    if (lock_i) begin
      if (req_i[grant_id_i]) begin
        grant_o[grant_id_i] = 1'b1;
        idx_o               = grant_id_i;
        any_o               = 1'b1;
      end
    end else begin
      // Walk from farthest to nearest so the nearest valid requester is the final winner.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
        if (req_i[cand]) begin
          grant_o       = '0;
          grant_o[cand] = 1'b1;
          idx_o         = cand;
          any_o         = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte-stream requesters.
// A grant is held for a whole packet; the byte is held on uart_data until the frame ends.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter  int BUSY_TIMEOUT = 4,
  localparam int IDX_W        = $clog2(NUM_REQ),
  localparam int CNT_W        = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus,
  output logic [IDX_W-1:0]   grant_id,
  output logic               grant_lock,
  output logic               timeout_err
);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      gid_q, gid_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic                  lock_q, lock_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  logic [IDX_W-1:0]      ptr_after_gid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i      (bus.req_valid),
    .ptr_i      (ptr_q),
    .lock_i     (lock_q),
    .grant_id_i (gid_q),
    .grant_o    (arb_grant),
    .idx_o      (arb_idx),
    .any_o      (arb_any)
  );

  assign ptr_after_gid = (gid_q == IDX_W'(NUM_REQ - 1)) ? '0 : gid_q + IDX_W'(1);

  always_comb begin
    state_d         = state_q;
    data_d          = data_q;
    gid_d           = gid_q;
    ptr_d           = ptr_q;
    lock_d          = lock_q;
    cnt_d           = cnt_q;
    bus.req_ready   = '0;
    bus.uart_enable = 1'b0;
    timeout_err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.uart_busy && !reset) begin
          bus.req_ready = arb_grant;
          if (arb_any) begin
            data_d  = bus.req_data[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
            gid_d   = arb_idx;
            lock_d  = ~bus.req_last[arb_idx];
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        // Gated so a stray busy level or a reset cycle can never start a second frame.
        bus.uart_enable = !bus.uart_busy && !reset;
        cnt_d           = '0;
        state_d         = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.uart_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT)) begin
          timeout_err = !reset;
          lock_d      = 1'b0;
          ptr_d       = ptr_after_gid;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (!bus.uart_busy) begin
          state_d = IDLE;
          if (!lock_q) ptr_d = ptr_after_gid;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      lock_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.uart_data = data_q;
  assign grant_id      = gid_q;
  assign grant_lock    = lock_q;

endmodule
